// File: rtl/regfile_wb_queue.sv
// In-order write-back queue feeding the register file write port, with youngest-first read forwarding.
// Latency: push at edge N retires at edge N+1 at the earliest; in_ready drops only when all DEPTH entries hold pending writes.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_wr,
    input  logic [31:0]   in_wd,
    input  logic          drain_en,
    output logic          RegWrite,
    output logic [4:0]    WR,
    output logic [31:0]   WD,
    input  logic [4:0]    RR1,
    input  logic [4:0]    RR2,
    output logic          fwd1_hit,
    output logic [31:0]   fwd1_data,
    output logic          fwd2_hit,
    output logic [31:0]   fwd2_data,
    output logic [AW:0]   count,
    output logic          empty
);

    typedef struct packed {
        logic [4:0]  wr;
        logic [31:0] wd;
    } entry_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [AW:0]      count_q, count_d;
    logic             push, pop;
    logic [AW-1:0]    fwd_idx;

    always_comb begin
        empty    = (count_q == '0);
        count    = count_q;
        in_ready = (count_q != DEPTH_C);
        pop      = !empty && drain_en;
        RegWrite = pop;
        WR       = empty ? 5'd0  : mem_q[head_q].wr;
        WD       = empty ? 32'd0 : mem_q[head_q].wd;
        // Writes to $0 are accepted but never occupy an entry.
        push     = in_valid && in_ready && (in_wr != 5'd0);
    end

    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + AW'(1);
        end
        if (push) begin
            mem_d[tail_q].wr = in_wr;
            mem_d[tail_q].wd = in_wd;
            valid_d[tail_q]  = 1'b1;
            tail_d           = tail_q + AW'(1);
        end
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = 32'd0;
        fwd2_hit  = 1'b0;
        fwd2_data = 32'd0;
        fwd_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + AW'(i);
            if (valid_q[fwd_idx] && (RR1 != 5'd0) && (mem_q[fwd_idx].wr == RR1)) begin
                fwd1_hit  = 1'b1;
                fwd1_data = mem_q[fwd_idx].wd;
            end
            if (valid_q[fwd_idx] && (RR2 != 5'd0) && (mem_q[fwd_idx].wr == RR2)) begin
                fwd2_hit  = 1'b1;
                fwd2_data = mem_q[fwd_idx].wd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q   <= '{default: '0};
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed cycle table, then random traffic against a queue-based model.
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, drain_en, RegWrite, empty;
    logic          fwd1_hit, fwd2_hit;
    logic [4:0]    in_wr, WR, RR1, RR2;
    logic [31:0]   in_wd, WD, fwd1_data, fwd2_data;
    logic [AW:0]   count;

    int checks   = 0;
    int failures = 0;

    regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_wr(in_wr), .in_wd(in_wd), .drain_en(drain_en), .RegWrite(RegWrite),
        .WR(WR), .WD(WD), .RR1(RR1), .RR2(RR2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    // Register file stand-in: captures the write port on the retiring edge.
    logic [31:0] rf [32];
    int          wr_cnt = 0;
    always @(posedge clk) begin
        if (RegWrite === 1'b1) begin
            rf[WR] <= WD;
            wr_cnt <= wr_cnt + 1;
        end
    end

    typedef struct {
        logic        rst, iv;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        de;
        logic [4:0]  r1, r2;
        logic        e_rdy, e_rw;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
        logic [2:0]  e_cnt;
        logic        e_h1;
        logic [31:0] e_d1;
        logic        e_h2;
        logic [31:0] e_d2;
    } vec_t;

    typedef struct {
        logic [4:0]  wr;
        logic [31:0] wd;
    } ent_t;

    vec_t tbl[$];
    ent_t mq[$];

    function automatic vec_t mk(input logic rst, input logic iv, input logic [4:0] wr, input logic [31:0] wd,
                                input logic de, input logic [4:0] r1, input logic [4:0] r2,
                                input logic rdy, input logic rw, input logic [4:0] ewr, input logic [31:0] ewd,
                                input logic [2:0] cnt, input logic h1, input logic [31:0] d1,
                                input logic h2, input logic [31:0] d2);
        vec_t v;
        v.rst = rst; v.iv = iv; v.wr = wr; v.wd = wd; v.de = de; v.r1 = r1; v.r2 = r2;
        v.e_rdy = rdy; v.e_rw = rw; v.e_wr = ewr; v.e_wd = ewd; v.e_cnt = cnt;
        v.e_h1 = h1; v.e_d1 = d1; v.e_h2 = h2; v.e_d2 = d2;
        return v;
    endfunction

    task automatic chk(input string nm, input int step, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", nm, step, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, check mid-cycle, then advance past the next edge.
    task automatic run(input vec_t v, input int step);
        reset = v.rst; in_valid = v.iv; in_wr = v.wr; in_wd = v.wd;
        drain_en = v.de; RR1 = v.r1; RR2 = v.r2;
        #4;
        chk("in_ready",  step, 32'(in_ready),  32'(v.e_rdy));
        chk("RegWrite",  step, 32'(RegWrite),  32'(v.e_rw));
        chk("WR",        step, 32'(WR),        32'(v.e_wr));
        chk("WD",        step, WD,             v.e_wd);
        chk("count",     step, 32'(count),     32'(v.e_cnt));
        chk("empty",     step, 32'(empty),     32'(v.e_cnt == 3'd0));
        chk("fwd1_hit",  step, 32'(fwd1_hit),  32'(v.e_h1));
        chk("fwd1_data", step, fwd1_data,      v.e_d1);
        chk("fwd2_hit",  step, 32'(fwd2_hit),  32'(v.e_h2));
        chk("fwd2_data", step, fwd2_data,      v.e_d2);
        @(posedge clk);
        #1;
    endtask

    task automatic model_lookup(input logic [4:0] rr, output logic hit, output logic [31:0] data);
        hit  = 1'b0;
        data = 32'd0;
        if (rr != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!hit && mq[i].wr == rr) begin
                    hit  = 1'b1;
                    data = mq[i].wd;
                end
            end
        end
    endtask

    task automatic model_expect(inout vec_t v);
        v.e_rdy = (mq.size() < DEPTH);
        v.e_rw  = (mq.size() > 0) && v.de;
        v.e_wr  = (mq.size() > 0) ? mq[0].wr : 5'd0;
        v.e_wd  = (mq.size() > 0) ? mq[0].wd : 32'd0;
        v.e_cnt = 3'(mq.size());
        model_lookup(v.r1, v.e_h1, v.e_d1);
        model_lookup(v.r2, v.e_h2, v.e_d2);
    endtask

    task automatic model_update(input vec_t v);
        ent_t e;
        if (v.rst) begin
            mq.delete();
        end else begin
            if (v.e_rw) void'(mq.pop_front());
            if (v.iv && v.e_rdy && v.wr != 5'd0) begin
                e.wr = v.wr;
                e.wd = v.wd;
                mq.push_back(e);
            end
        end
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 32; i++) rf[i] = 32'hDEAD_BEEF;
        reset = 1'b1; in_valid = 1'b1; in_wr = 5'd5; in_wd = 32'd9;
        drain_en = 1'b1; RR1 = 5'd0; RR2 = 5'd0;

        //                rst iv wr  wd   de r1  r2   rdy rw ewr ewd cnt h1 d1   h2 d2
        tbl.push_back(mk(1, 1, 5,  9,   1, 0,  0,   1, 0, 0,  0,  0,  0, 0,   0, 0));
        tbl.push_back(mk(0, 0, 0,  0,   1, 0,  0,   1, 0, 0,  0,  0,  0, 0,   0, 0));
        tbl.push_back(mk(0, 1, 2,  23,  1, 2,  0,   1, 0, 0,  0,  0,  0, 0,   0, 0));
        tbl.push_back(mk(0, 0, 0,  0,   1, 2,  0,   1, 1, 2,  23, 1,  1, 23,  0, 0));
        tbl.push_back(mk(0, 0, 0,  0,   1, 2,  0,   1, 0, 0,  0,  0,  0, 0,   0, 0));
        tbl.push_back(mk(0, 1, 2,  23,  1, 0,  0,   1, 0, 0,  0,  0,  0, 0,   0, 0));
        tbl.push_back(mk(0, 1, 3,  28,  1, 3,  0,   1, 1, 2,  23, 1,  0, 0,   0, 0));
        tbl.push_back(mk(0, 1, 1,  55,  1, 0,  0,   1, 1, 3,  28, 1,  0, 0,   0, 0));
        tbl.push_back(mk(0, 0, 0,  0,   1, 0,  0,   1, 1, 1,  55, 1,  0, 0,   0, 0));
        tbl.push_back(mk(0, 0, 0,  0,   1, 0,  0,   1, 0, 0,  0,  0,  0, 0,   0, 0));
        tbl.push_back(mk(0, 1, 4,  1,   0, 0,  0,   1, 0, 0,  0,  0,  0, 0,   0, 0));
        tbl.push_back(mk(0, 1, 5,  2,   0, 4,  0,   1, 0, 4,  1,  1,  1, 1,   0, 0));
        tbl.push_back(mk(0, 1, 6,  3,   0, 0,  0,   1, 0, 4,  1,  2,  0, 0,   0, 0));
        tbl.push_back(mk(0, 1, 7,  4,   0, 0,  0,   1, 0, 4,  1,  3,  0, 0,   0, 0));
        tbl.push_back(mk(0, 1, 8,  5,   0, 7,  0,   0, 0, 4,  1,  4,  1, 4,   0, 0));
        tbl.push_back(mk(0, 1, 8,  5,   1, 0,  0,   0, 1, 4,  1,  4,  0, 0,   0, 0));
        tbl.push_back(mk(0, 1, 8,  5,   1, 8,  0,   1, 1, 5,  2,  3,  0, 0,   0, 0));
        tbl.push_back(mk(0, 0, 0,  0,   1, 8,  0,   1, 1, 6,  3,  3,  1, 5,   0, 0));
        tbl.push_back(mk(0, 0, 0,  0,   1, 0,  0,   1, 1, 7,  4,  2,  0, 0,   0, 0));
        tbl.push_back(mk(0, 0, 0,  0,   1, 0,  0,   1, 1, 8,  5,  1,  0, 0,   0, 0));
        tbl.push_back(mk(0, 0, 0,  0,   1, 0,  0,   1, 0, 0,  0,  0,  0, 0,   0, 0));
        tbl.push_back(mk(0, 1, 9,  100, 0, 9,  0,   1, 0, 0,  0,  0,  0, 0,   0, 0));
        tbl.push_back(mk(0, 1, 9,  200, 0, 9,  0,   1, 0, 9,  100, 1, 1, 100, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0,   0, 9,  0,   1, 0, 9,  100, 2, 1, 200, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0,   1, 9,  9,   1, 1, 9,  100, 2, 1, 200, 1, 200));
        tbl.push_back(mk(0, 0, 0,  0,   1, 9,  0,   1, 1, 9,  200, 1, 1, 200, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0,   1, 9,  0,   1, 0, 0,  0,  0,  0, 0,   0, 0));
        tbl.push_back(mk(0, 1, 0,  77,  1, 0,  0,   1, 0, 0,  0,  0,  0, 0,   0, 0));
        tbl.push_back(mk(0, 0, 0,  0,   1, 0,  0,   1, 0, 0,  0,  0,  0, 0,   0, 0));
        tbl.push_back(mk(0, 1, 10, 1,   0, 0,  0,   1, 0, 0,  0,  0,  0, 0,   0, 0));
        tbl.push_back(mk(0, 1, 11, 2,   0, 0,  0,   1, 0, 10, 1,  1,  0, 0,   0, 0));
        tbl.push_back(mk(0, 1, 12, 3,   0, 0,  0,   1, 0, 10, 1,  2,  0, 0,   0, 0));
        tbl.push_back(mk(0, 0, 0,  0,   0, 11, 12,  1, 0, 10, 1,  3,  1, 2,   1, 3));
        tbl.push_back(mk(1, 1, 13, 4,   0, 11, 0,   1, 0, 10, 1,  3,  1, 2,   0, 0));
        tbl.push_back(mk(0, 0, 0,  0,   1, 11, 0,   1, 0, 0,  0,  0,  0, 0,   0, 0));
        tbl.push_back(mk(0, 0, 0,  0,   1, 0,  0,   1, 0, 0,  0,  0,  0, 0,   0, 0));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) run(tbl[i], i);

        chk("rf_writes", 0, 32'(wr_cnt), 32'd11);
        chk("rf[2]",  0, rf[2],  32'd23);
        chk("rf[3]",  0, rf[3],  32'd28);
        chk("rf[1]",  0, rf[1],  32'd55);
        chk("rf[4]",  0, rf[4],  32'd1);
        chk("rf[8]",  0, rf[8],  32'd5);
        chk("rf[9]",  0, rf[9],  32'd200);
        chk("rf[0]",  0, rf[0],  32'hDEAD_BEEF);
        chk("rf[10]", 0, rf[10], 32'hDEAD_BEEF);
        chk("rf[13]", 0, rf[13], 32'hDEAD_BEEF);

        mq.delete();
        for (int n = 0; n < 3000; n++) begin
            v.rst = (n == 0) || ($urandom_range(0, 63) == 0);
            v.iv  = ($urandom_range(0, 9) < 7);
            v.wr  = 5'($urandom_range(0, 7));
            v.wd  = $urandom;
            v.de  = ($urandom_range(0, 9) < 5);
            v.r1  = 5'($urandom_range(0, 7));
            v.r2  = 5'($urandom_range(0, 7));
            if (n == 0) begin
                // The queue is already empty here, so the model's view is valid before the first reset row.
                mq.delete();
            end
            model_expect(v);
            run(v, 1000 + n);
            model_update(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-back side of the MIPS register file interface: the initiator that drives the file's RegWrite/WR/WD write port.
- Buffers results from the execute/memory stages in an in-order FIFO and retires at most one write per cycle into the register file.
- Provides read-side forwarding of pending (not yet retired) results, so decode reads on RR1/RR2 see the newest value.

Parameters:
- DEPTH, 4, number of queue entries (power of two, >=2).
- AW, 2, pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer offers a result this cycle.
- in_ready  output  1  queue accepts a result this cycle.
- in_wr  input  5  destination register number.
- in_wd  input  32  result data.
- drain_en  input  1  register-file write port available this cycle.
- RegWrite  output  1  write enable to the register file.
- WR  output  5  write register number to the register file.
- WD  output  32  write data to the register file.
- RR1  input  5  decode read address 1, same value sent to the register file.
- RR2  input  5  decode read address 2.
- fwd1_hit  output  1  a pending entry targets RR1.
- fwd1_data  output  32  data of the youngest pending entry targeting RR1.
- fwd2_hit  output  1  same as fwd1_hit, for RR2.
- fwd2_data  output  32  same as fwd1_data, for RR2.
- count  output  AW+1  number of valid entries.
- empty  output  1  count == 0.

Behaviour:
- Reset (sync, high): entries invalidated, pointers 0, count=0, empty=1, RegWrite=0, WR=0, WD=0, fwd hits 0, fwd data 0, in_ready=1. Reset wins over any simultaneous push or pop.
- Push: on a clock edge when in_valid && in_ready, with in_wr != 0, in_wr/in_wd are written at the tail and the tail advances, wrapping mod DEPTH.
- Writes to $0: in_valid && in_ready with in_wr == 0 is accepted and discarded. No entry is created and count is unchanged.
- in_ready = (count < DEPTH), combinational from state only, with no dependence on drain_en.
- RegWrite = !empty && drain_en, combinational. WR/WD = head entry whenever the queue is non-empty, otherwise 0.
- Pop: on a clock edge when RegWrite=1 the head advances, wrapping. The register file captures WR/WD on that same edge.
- Minimum latency: a result pushed at edge N is driven on WR/WD during cycle N..N+1 and is written into the register file at edge N+1 (if drain_en=1).
- Simultaneous push and pop: count unchanged and both pointers advance. This is legal at any count < DEPTH.
- Full (count == DEPTH): in_ready=0 even if a pop occurs in the same cycle. No push-when-full bypass.
- Ordering: strict FIFO. Two pending writes to the same register retire in arrival order.
- Forwarding:
  - Combinational from current entries, including the head being retired this cycle.
  - fwdN_hit=1 iff RRN != 0 and some valid entry has wr == RRN.
  - fwdN_data = data of the youngest such entry (closest to tail), else 0.
  - The incoming in_* beat is NOT forwarded in its arrival cycle.
- drain_en=0 freezes retirement only. Pushes, forwarding and count remain active.
- Pointer wrap: count is derived from the push/pop events, not from pointer difference, so full vs empty is unambiguous.

Test Plan:
- Reset then idle: assert reset 2 cycles with in_valid=1 -> count=0, RegWrite=0, WR=0, WD=0, in_ready=1, nothing enqueued.
- Single write: push (wr=2, wd=23) with drain_en=1 -> next cycle RegWrite=1, WR=2, WD=23. After that edge: empty=1, register file reading RR1=2 returns 23.
- Back-to-back: push (2,23), (3,28), (1,55) on consecutive cycles with drain_en=1 -> WR sequence 2,3,1 on consecutive cycles, count never exceeds 1, file holds 23/28/55.
- Fill and stall: drain_en=0, push 5 beats (4,1)..(7,4),(8,5) -> first 4 accepted, in_ready=0 on the 5th, count=4. Then drain_en=1 -> 4 writes in order, and the 5th beat is accepted once in_ready returns to 1.
- Forwarding priority: drain_en=0, push (9,100) then (9,200), RR1=9, RR2=0 -> fwd1_hit=1, fwd1_data=200, fwd2_hit=0. After draining both, fwd1_hit=0.
- $0 and mid-operation reset: push (0,77) -> count unchanged, no write issued. With count=3 assert reset -> count=0, RegWrite=0 on the next cycle, no further writes.
